// File: rtl/flip_col_scheduler.sv
// Schedules the flipped columns of a sigma pair (sigma_old ^ sigma_new) onto
// COL_PER_CC lanes per beat, lowest index first, for a downstream compute unit.
module flip_col_scheduler #(
    parameter int VECTOR_SIZE = 256,
    parameter int COL_PER_CC  = 4,
    parameter int IDX_W       = $clog2(VECTOR_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic [VECTOR_SIZE-1:0]      sigma_old_i,
    input  logic [VECTOR_SIZE-1:0]      sigma_new_i,
    input  logic                        ready_i,
    output logic                        beat_valid_o,
    output logic [COL_PER_CC*IDX_W-1:0] col_idx_o,
    output logic [COL_PER_CC-1:0]       sigma_c_o,
    output logic [COL_PER_CC-1:0]       valid_o,
    output logic [COL_PER_CC-1:0]       final_flag_o,
    output logic                        clear_o,
    output logic [VECTOR_SIZE-1:0]      sigma_new_o,
    output logic [IDX_W:0]              flip_count_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [1:0]                  state_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;

    // Handshake: a beat transfers on any posedge where beat_valid_o && ready_i;
    // beat outputs depend only on registered state, so they hold during stalls
    // and ready_i never reaches an output combinationally.

    logic [1:0]             state_q;
    logic [VECTOR_SIZE-1:0] mask_q;
    logic [VECTOR_SIZE-1:0] sigma_new_q;
    logic [IDX_W:0]         flip_count_q;
    logic                   done_q;

    logic [VECTOR_SIZE-1:0] pick_mask;
    logic [IDX_W-1:0]       lane_idx [COL_PER_CC];
    logic [COL_PER_CC-1:0]  lane_valid;
    logic [COL_PER_CC-1:0]  lane_sigma;
    logic [COL_PER_CC-1:0]  lane_final;
    logic                   lane_found;
    logic                   last_beat;
    logic                   issue;

    function automatic logic [IDX_W:0] popcount(input logic [VECTOR_SIZE-1:0] v);
        logic [IDX_W:0] n;
        n = '0;
        for (int i = 0; i < VECTOR_SIZE; i++) begin
            n = n + {{IDX_W{1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Priority chain: each lane takes the lowest bit left over by the lanes below it.
    always_comb begin
        pick_mask  = mask_q;
        lane_valid = '0;
        lane_sigma = '0;
        lane_found = 1'b0;
        for (int k = 0; k < COL_PER_CC; k++) begin
            lane_idx[k] = '0;
            lane_found  = 1'b0;
            for (int i = 0; i < VECTOR_SIZE; i++) begin
                if (!lane_found && pick_mask[i]) begin
                    lane_found   = 1'b1;
                    lane_idx[k]  = IDX_W'(i);
                    pick_mask[i] = 1'b0;
                end
            end
            lane_valid[k] = lane_found;
            lane_sigma[k] = lane_found & sigma_new_q[lane_idx[k]];
        end
        last_beat  = (pick_mask == '0);
        lane_final = '0;
        if (last_beat) begin
            if (lane_valid == '0) begin
                lane_final[0] = 1'b1;
            end else begin
                for (int k = 0; k < COL_PER_CC; k++) begin
                    if (lane_valid[k]) begin
                        lane_final    = '0;
                        lane_final[k] = 1'b1;
                    end
                end
            end
        end
    end

    assign issue = (state_q == ISSUE);

    always_comb begin
        col_idx_o = '0;
        for (int k = 0; k < COL_PER_CC; k++) begin
            col_idx_o[k*IDX_W +: IDX_W] = issue ? lane_idx[k] : '0;
        end
    end

    assign beat_valid_o = issue;
    assign valid_o      = issue ? lane_valid : '0;
    assign sigma_c_o    = issue ? lane_sigma : '0;
    assign final_flag_o = issue ? lane_final : '0;
    assign clear_o      = (state_q == CLEAR);
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign sigma_new_o  = sigma_new_q;
    assign flip_count_o = flip_count_q;
    assign state_o      = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            sigma_new_q  <= '0;
            flip_count_q <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mask_q       <= sigma_old_i ^ sigma_new_i;
                        sigma_new_q  <= sigma_new_i;
                        flip_count_q <= popcount(sigma_old_i ^ sigma_new_i);
                        state_q      <= CLEAR;
                    end
                end
                CLEAR: begin
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    if (ready_i) begin
                        mask_q <= pick_mask;
                        if (last_beat) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flip_col_scheduler.sv
// Directed bench for flip_col_scheduler: expected beats are queued at issue time
// and a negedge monitor compares every presented beat against the queue head.
module tb_flip_col_scheduler;

    localparam int VS  = 256;
    localparam int CPC = 4;
    localparam int IW  = 8;
    localparam int W   = CPC*IW + 3*CPC;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic            ready_i;
    logic [VS-1:0]   sigma_old_i;
    logic [VS-1:0]   sigma_new_i;
    logic            beat_valid_o;
    logic [CPC*IW-1:0] col_idx_o;
    logic [CPC-1:0]  sigma_c_o;
    logic [CPC-1:0]  valid_o;
    logic [CPC-1:0]  final_flag_o;
    logic            clear_o;
    logic [VS-1:0]   sigma_new_o;
    logic [IW:0]     flip_count_o;
    logic            busy_o;
    logic            done_o;
    logic [1:0]      state_o;

    int checks   = 0;
    int errors   = 0;
    int beat_cnt = 0;
    int job_base = 0;

    logic [W-1:0] exp_q[$];
    logic [IW:0]  fc_q[$];

    flip_col_scheduler #(.VECTOR_SIZE(VS), .COL_PER_CC(CPC)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .sigma_old_i  (sigma_old_i),
        .sigma_new_i  (sigma_new_i),
        .ready_i      (ready_i),
        .beat_valid_o (beat_valid_o),
        .col_idx_o    (col_idx_o),
        .sigma_c_o    (sigma_c_o),
        .valid_o      (valid_o),
        .final_flag_o (final_flag_o),
        .clear_o      (clear_o),
        .sigma_new_o  (sigma_new_o),
        .flip_count_o (flip_count_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .state_o      (state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [VS-1:0] act, input logic [VS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pk(input int i0, input int i1, input int i2, input int i3,
                                        input logic [3:0] sc, input logic [3:0] v, input logic [3:0] f);
        return {IW'(i3), IW'(i2), IW'(i1), IW'(i0), sc, v, f};
    endfunction

    // Reference: list set bits ascending, chunk them CPC at a time.
    function automatic void model_push(input logic [VS-1:0] f, input logic [VS-1:0] sn);
        int set_bits[$];
        int lanes[CPC];
        logic [3:0] sc, v, fl;
        int n, nb;
        for (int i = 0; i < VS; i++) if (f[i]) set_bits.push_back(i);
        n  = set_bits.size();
        nb = (n + CPC - 1) / CPC;
        fc_q.push_back((IW+1)'(n));
        if (n == 0) begin
            exp_q.push_back(pk(0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0001));
        end else begin
            for (int b = 0; b < nb; b++) begin
                sc = '0; v = '0; fl = '0;
                for (int k = 0; k < CPC; k++) begin
                    lanes[k] = 0;
                    if (b*CPC + k < n) begin
                        lanes[k] = set_bits[b*CPC + k];
                        v[k]     = 1'b1;
                        sc[k]    = sn[lanes[k]];
                    end
                end
                if (b == nb - 1) fl[(n-1) % CPC] = 1'b1;
                exp_q.push_back(pk(lanes[0], lanes[1], lanes[2], lanes[3], sc, v, fl));
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic job_begin(input logic [VS-1:0] so, input logic [VS-1:0] sn);
        job_base    = beat_cnt;
        sigma_old_i = so;
        sigma_new_i = sn;
        start_i     = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        check("clear_pulse", clear_o, 1);
        check("busy_in_clear", busy_o, 1);
        check("no_beat_in_clear", beat_valid_o, 0);
        @(posedge clk); #1;
        check("first_beat_latency", beat_valid_o, 1);
        check("clear_one_cycle", clear_o, 0);
    endtask

    task automatic job_wait_done(input logic [VS-1:0] sn, input int exp_beats, input bit toggle);
        int cyc = 0;
        while (done_o !== 1'b1 && cyc < 1000) begin
            ready_i = toggle ? (cyc % 2 == 0) : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        ready_i = 1'b1;
        check("done_timeout", (cyc < 1000), 1);
        check("beat_count", beat_cnt - job_base, exp_beats);
        check("exp_drained", exp_q.size(), 0);
        check("sigma_new_hold", sigma_new_o, sn);
        check("idle_at_done", busy_o, 0);
    endtask

    task automatic run_job(input logic [VS-1:0] so, input logic [VS-1:0] sn,
                           input int exp_beats, input bit toggle);
        job_begin(so, sn);
        job_wait_done(sn, exp_beats, toggle);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (beat_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", beat_valid_o, 0);
                end else begin
                    check("beat", {col_idx_o, sigma_c_o, valid_o, final_flag_o}, exp_q[0]);
                    if (ready_i) begin
                        void'(exp_q.pop_front());
                        beat_cnt++;
                    end
                end
            end
            if (clear_o) begin
                if (fc_q.size() == 0) check("clear_unexpected", clear_o, 0);
                else check("flip_count", flip_count_o, fc_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [VS-1:0] so, sn, pat;

    initial begin
        rst = 1'b1; start_i = 1'b0; ready_i = 1'b0;
        sigma_old_i = '0; sigma_new_i = '0;
        pat = {8{32'hA5C3_0F96}};
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {beat_valid_o, valid_o, final_flag_o, col_idx_o, sigma_c_o,
                              clear_o, done_o, busy_o, flip_count_o}, 0);
        check("rst_sigma_new", sigma_new_o, 0);
        rst = 1'b0;
        ready_i = 1'b1;
        @(posedge clk); #1;

        // Equal vectors: single empty beat with final on lane 0.
        exp_q.push_back(pk(0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0001));
        fc_q.push_back(9'd0);
        run_job(pat, pat, 1, 1'b0);

        // Flips at 3 and 7 (bit 100 set in both, not flipped).
        so = '0; so[3] = 1'b1; so[100] = 1'b1;
        sn = '0; sn[7] = 1'b1; sn[100] = 1'b1;
        exp_q.push_back(pk(3, 7, 0, 0, 4'b0010, 4'b0011, 4'b0010));
        fc_q.push_back(9'd2);
        run_job(so, sn, 1, 1'b0);

        // Flips at 0..4, started in the done cycle of the previous job.
        so = '0; so[4:0] = 5'b01010;
        sn = '0; sn[4:0] = 5'b10101;
        exp_q.push_back(pk(0, 1, 2, 3, 4'b0101, 4'b1111, 4'b0000));
        exp_q.push_back(pk(4, 0, 0, 0, 4'b0001, 4'b0001, 4'b0001));
        fc_q.push_back(9'd5);
        run_job(so, sn, 2, 1'b0);

        // Single flip at the top index.
        so = '0; so[255] = 1'b1;
        sn = '0;
        exp_q.push_back(pk(255, 0, 0, 0, 4'b0000, 4'b0001, 4'b0001));
        fc_q.push_back(9'd1);
        run_job(so, sn, 1, 1'b0);

        // Sparse pattern, exactly two full beats.
        so = pat;
        sn = pat;
        sn[1] = ~sn[1]; sn[2] = ~sn[2]; sn[64] = ~sn[64]; sn[65] = ~sn[65];
        sn[66] = ~sn[66]; sn[130] = ~sn[130]; sn[200] = ~sn[200]; sn[254] = ~sn[254];
        model_push(so ^ sn, sn);
        run_job(so, sn, 2, 1'b1);

        // All bits flipped with ready toggling: 64 beats, stalls must hold.
        so = pat;
        sn = ~pat;
        model_push(so ^ sn, sn);
        check("all_flip_final_beat", exp_q[63][3:0], 4'b1000);
        run_job(so, sn, 64, 1'b1);
        check("all_flip_count", flip_count_o, 9'd256);

        // Mid-ISSUE start is ignored, then reset drops the job.
        so = pat;
        sn = ~pat;
        model_push(so ^ sn, sn);
        job_begin(so, sn);
        ready_i = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        sigma_old_i = '0; sigma_new_i = '1; start_i = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        start_i = 1'b0;
        check("start_ignored_state", state_o, 2'd2);
        check("start_ignored_beat", beat_valid_o, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        fc_q.delete();
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_beat", beat_valid_o, 0);
        check("rst_mid_done", done_o, 0);
        check("rst_mid_sigma_new", sigma_new_o, 0);
        @(posedge clk); #1;
        check("no_done_after_rst", done_o, 0);

        // Reset wins over a simultaneous start.
        sigma_old_i = '0; sigma_new_i = pat;
        rst = 1'b1; start_i = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start_i = 1'b0;
        check("rst_over_start_busy", busy_o, 0);
        @(posedge clk); #1;
        check("rst_over_start_clear", clear_o, 0);

        // Fresh job after reset runs normally.
        so = '0; so[3] = 1'b1;
        sn = '0; sn[7] = 1'b1;
        exp_q.push_back(pk(3, 7, 0, 0, 4'b0010, 4'b0011, 4'b0010));
        fc_q.push_back(9'd2);
        run_job(so, sn, 1, 1'b0);

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
